// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed program memory that answers a single
// outstanding fetch with data plus a one-cycle ack after LATENCY cycles.
// A side write port loads program words and runs independently of the fetch FSM.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no request in flight, next valid unflushed request accepted
//   S_WAIT | request latched, latency counter running down to zero
//   S_RESP | ack cycle; request and flush ignored, returns to S_IDLE
module instr_mem_responder #(
  parameter int                IWIDTH  = 32,
  parameter int                AWIDTH  = 32,
  parameter int                DEPTH   = 1024,
  parameter int                LATENCY = 1,
  parameter logic [IWIDTH-1:0] NOP     = 32'h00000013
) (
  input  logic              im_clk,
  input  logic              im_rst,
  input  logic              im_i_syn,
  input  logic [AWIDTH-1:0] im_i_addr,
  input  logic              im_i_flush,
  output logic [IWIDTH-1:0] im_o_instr,
  output logic              im_o_ack,
  output logic              im_o_err,
  output logic              im_o_busy,
  input  logic              im_i_we,
  input  logic [AWIDTH-1:0] im_i_waddr,
  input  logic [IWIDTH-1:0] im_i_wdata
);

  localparam int                IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNTW     = 4;
  localparam logic [AWIDTH-3:0] DEPTH_W  = (AWIDTH-2)'(DEPTH);
  localparam logic [CNTW-1:0]   CNT_LOAD = CNTW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [IWIDTH-1:0] instr_q, instr_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [IWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-3:0] rd_word;
  logic [IDXW-1:0]   rd_idx;
  logic              rd_bad;
  logic [IWIDTH-1:0] rd_data;

  logic [AWIDTH-3:0] wr_word;
  logic [IDXW-1:0]   wr_idx;
  logic              wr_ok;

  // The fetch decode works on the latched address, so the initiator may change
  // its address lines once the request has been accepted.
  assign rd_word = addr_q[AWIDTH-1:2];
  assign rd_idx  = rd_word[IDXW-1:0];
  assign rd_bad  = (addr_q[1:0] != 2'b00) || (rd_word >= DEPTH_W);
  assign rd_data = mem[rd_idx];

  assign wr_word = im_i_waddr[AWIDTH-1:2];
  assign wr_idx  = wr_word[IDXW-1:0];
  assign wr_ok   = (im_i_waddr[1:0] == 2'b00) && (wr_word < DEPTH_W);

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (im_i_syn && !im_i_flush) begin
          state_d = S_WAIT;
          addr_d  = im_i_addr;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (im_i_flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          instr_d = rd_bad ? NOP : rd_data;
          err_d   = rd_bad;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any request in flight.
  always_ff @(posedge im_clk) begin
    if (im_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Program load port; misaligned or out-of-range writes are dropped so they
  // cannot alias onto a valid word. Contents survive reset.
  always_ff @(posedge im_clk) begin
    if (im_i_we && wr_ok) begin
      mem[wr_idx] <= im_i_wdata;
    end
  end

  assign im_o_instr = instr_q;
  assign im_o_ack   = ack_q;
  assign im_o_err   = err_q;
  assign im_o_busy  = busy_q;

endmodule
